// File: rtl/jno_branch_ctrl_pkg.sv
// Shared constants for the jump-if-no-overflow controller: instruct codes,
// FSM state encoding and default widths.
package jno_branch_ctrl_pkg;

  localparam int JNO_PC_W   = 8;
  localparam int JNO_OFFS_W = 8;
  localparam int JNO_CNT_W  = 2;

  // 2'b11 belongs to the downstream override and is never driven here.
  typedef enum logic [1:0] {
    INSTR_SEQ   = 2'b00,
    INSTR_STALL = 2'b01,
    INSTR_TAKEN = 2'b10,
    INSTR_RSVD  = 2'b11
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ISSUE = 2'b10
  } state_t;

endpackage

// File: rtl/jno_branch_ctrl_if.sv
// Bundle of the ALU, decoder and fetch-redirect signals of the JNO controller.
// Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
// the producer holds its payload stable while valid=1 and ready=0.
interface jno_branch_ctrl_if
  import jno_branch_ctrl_pkg::*;
#(
  parameter int PC_W   = JNO_PC_W,
  parameter int OFFS_W = JNO_OFFS_W
);
  logic              flush;
  logic              alu_issue;
  logic              alu_ready;
  logic              flag_we;
  logic              ovf_in;
  logic              dec_valid;
  logic              dec_is_jno;
  logic [PC_W-1:0]   dec_pc;
  logic [OFFS_W-1:0] dec_offset;
  logic              dec_ready;
  logic [1:0]        instruct_from_jno;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              redirect_ready;
  state_t            dbg_state;

  modport slave (
    input  flush, alu_issue, flag_we, ovf_in, dec_valid, dec_is_jno,
           dec_pc, dec_offset, redirect_ready,
    output alu_ready, dec_ready, instruct_from_jno, redirect_valid,
           redirect_pc, dbg_state
  );

  modport master (
    output flush, alu_issue, flag_we, ovf_in, dec_valid, dec_is_jno,
           dec_pc, dec_offset, redirect_ready,
    input  alu_ready, dec_ready, instruct_from_jno, redirect_valid,
           redirect_pc, dbg_state
  );
endinterface

// File: rtl/jno_pend_counter.sv
// Saturating up/down counter of ALU ops still owing an overflow-flag write.
// Also exposes the post-update value so the FSM can resolve in the same cycle.
module jno_pend_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt_next,
    output logic             o_full
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Simultaneous inc and dec cancel; both ends clamp instead of wrapping.
    always_comb begin
        w_cnt_next = r_cnt;
        if (i_inc && !i_dec && (r_cnt != CNT_MAX))
            w_cnt_next = r_cnt + CNT_W'(1);
        else if (i_dec && !i_inc && (r_cnt != '0))
            w_cnt_next = r_cnt - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else          r_cnt <= w_cnt_next;
    end

    assign o_cnt_next = w_cnt_next;
    assign o_full     = (r_cnt == CNT_MAX);
endmodule

// File: rtl/jno_branch_ctrl.sv
// Holds a decoded JNO until the overflow flag is final, then either drops it
// or issues the jump target to fetch as a redirect.
module jno_branch_ctrl
  import jno_branch_ctrl_pkg::*;
#(
    parameter int PC_W   = JNO_PC_W,
    parameter int OFFS_W = JNO_OFFS_W,
    parameter int CNT_W  = JNO_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    jno_branch_ctrl_if.slave  bus
);
    state_t            r_state;
    state_t            w_state_next;
    logic              r_ovf;
    logic              w_ovf_next;
    logic [PC_W-1:0]   r_cap_pc;
    logic [OFFS_W-1:0] r_cap_off;
    logic [PC_W-1:0]   w_target;
    logic [CNT_W-1:0]  w_pend_next;
    logic              w_pend_full;
    logic              w_pend_clear;
    logic              w_accept_jno;

    jno_pend_counter #(.CNT_W(CNT_W)) u_pend (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_inc      (bus.alu_issue),
        .i_dec      (bus.flag_we),
        .o_cnt_next (w_pend_next),
        .o_full     (w_pend_full)
    );

    // The flag value as it will stand after this edge, so a same-cycle write resolves at once.
    assign w_ovf_next   = bus.flag_we ? bus.ovf_in : r_ovf;
    assign w_pend_clear = (w_pend_next == '0);
    assign w_accept_jno = bus.dec_valid && bus.dec_ready && bus.dec_is_jno && !bus.flush;
    assign w_target     = r_cap_pc + PC_W'($signed(r_cap_off));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf     <= 1'b0;
            r_cap_pc  <= '0;
            r_cap_off <= '0;
        end else begin
            r_ovf <= w_ovf_next;
            if (w_accept_jno) begin
                r_cap_pc  <= bus.dec_pc;
                r_cap_off <= bus.dec_offset;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_jno) begin
                        if (!w_pend_clear)   w_state_next = ST_WAIT;
                        else if (!w_ovf_next) w_state_next = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (w_pend_clear) w_state_next = w_ovf_next ? ST_IDLE : ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.redirect_ready) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.dec_ready         = 1'b0;
        bus.instruct_from_jno = INSTR_SEQ;
        bus.redirect_valid    = 1'b0;
        bus.redirect_pc       = '0;
        case (r_state)
            ST_IDLE:  bus.dec_ready = 1'b1;
            ST_WAIT:  bus.instruct_from_jno = INSTR_STALL;
            ST_ISSUE: begin
                bus.instruct_from_jno = INSTR_TAKEN;
                bus.redirect_valid    = 1'b1;
                bus.redirect_pc       = w_target;
            end
            default: bus.dec_ready = 1'b1;
        endcase
    end

    assign bus.alu_ready = !w_pend_full;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_jno_branch_ctrl.sv
// Bench for jno_branch_ctrl: directed scenarios plus a redirect scoreboard.
module tb_jno_branch_ctrl;
  import jno_branch_ctrl_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  jno_branch_ctrl_if #(.PC_W(8), .OFFS_W(8)) bus ();

  jno_branch_ctrl #(.PC_W(8), .OFFS_W(8), .CNT_W(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (bus.instruct_from_jno === 2'b11) begin
        errors++;
        $display("FAIL rsvd_code: instruct=%b required not 11", bus.instruct_from_jno);
      end
      if (bus.redirect_valid && bus.redirect_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_redirect: pc=%h required no redirect", bus.redirect_pc);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.redirect_pc !== e) begin
            errors++;
            $display("FAIL redirect_pc: got %h required %h", bus.redirect_pc, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.flush = 0; bus.alu_issue = 0; bus.flag_we = 0; bus.ovf_in = 0;
    bus.dec_valid = 0; bus.dec_is_jno = 0; bus.dec_pc = '0; bus.dec_offset = '0;
    bus.redirect_ready = 0;
  endtask

  task automatic drive_jno(input logic [7:0] pc, input logic [7:0] off);
    bus.dec_valid = 1; bus.dec_is_jno = 1; bus.dec_pc = pc; bus.dec_offset = off;
    tick();
    bus.dec_valid = 0; bus.dec_is_jno = 0;
  endtask

  function automatic logic [7:0] model_target(input logic [7:0] pc, input logic [7:0] off);
    int t;
    t = int'(pc) + int'($signed(off));
    return t[7:0];
  endfunction

  task automatic take_redirect();
    bus.redirect_ready = 1;
    tick();
    bus.redirect_ready = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if (bus.instruct_from_jno !== 2'b00 || bus.redirect_valid !== 1'b0 ||
        bus.redirect_pc !== 8'h00 || bus.dec_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: instr=%b rv=%b rpc=%h dr=%b ar=%b required 00 0 00 1 1",
               bus.instruct_from_jno, bus.redirect_valid, bus.redirect_pc,
               bus.dec_ready, bus.alu_ready);
    end
  endtask

  task automatic test_taken_hold();
    exp_q.push_back(model_target(8'h10, 8'h05));
    drive_jno(8'h10, 8'h05);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.instruct_from_jno !== 2'b10 || bus.redirect_valid !== 1'b1 ||
          bus.redirect_pc !== 8'h15 || bus.dec_ready !== 1'b0) begin
        errors++;
        $display("FAIL taken_hold[%0d]: instr=%b rv=%b rpc=%h dr=%b required 10 1 15 0",
                 i, bus.instruct_from_jno, bus.redirect_valid, bus.redirect_pc, bus.dec_ready);
      end
      if (i < 3) tick();
    end
    take_redirect();
    checks++;
    if (bus.instruct_from_jno !== 2'b00 || bus.redirect_valid !== 1'b0 || bus.dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL taken_release: instr=%b rv=%b required 00 0", bus.instruct_from_jno, bus.redirect_valid);
    end
  endtask

  task automatic test_neg_wrap();
    exp_q.push_back(8'hFE);
    drive_jno(8'h02, 8'hFC);
    checks++;
    if (bus.redirect_pc !== 8'hFE || bus.redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL neg_wrap: rpc=%h rv=%b required fe 1", bus.redirect_pc, bus.redirect_valid);
    end
    take_redirect();
  endtask

  task automatic test_pending();
    bus.alu_issue = 1; tick(); tick(); bus.alu_issue = 0;
    drive_jno(8'h30, 8'h04);
    checks++;
    if (bus.instruct_from_jno !== 2'b01 || bus.dec_ready !== 1'b0 || bus.dbg_state !== ST_WAIT) begin
      errors++;
      $display("FAIL pend_stall: instr=%b dr=%b required 01 0", bus.instruct_from_jno, bus.dec_ready);
    end
    bus.flag_we = 1; bus.ovf_in = 0; tick();
    checks++;
    if (bus.instruct_from_jno !== 2'b01) begin
      errors++;
      $display("FAIL pend_first_write: instr=%b required 01", bus.instruct_from_jno);
    end
    bus.ovf_in = 1; tick();
    bus.flag_we = 0; bus.ovf_in = 0;
    checks++;
    if (bus.instruct_from_jno !== 2'b00 || bus.redirect_valid !== 1'b0 || bus.dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL pend_not_taken: instr=%b rv=%b dr=%b required 00 0 1",
               bus.instruct_from_jno, bus.redirect_valid, bus.dec_ready);
    end
    // Flag now 1 with nothing pending: a JNO resolves not-taken without stalling.
    drive_jno(8'h50, 8'h01);
    checks++;
    if (bus.instruct_from_jno !== 2'b00 || bus.dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_stall_not_taken: instr=%b dr=%b required 00 1", bus.instruct_from_jno, bus.dec_ready);
    end
    bus.flag_we = 1; bus.ovf_in = 0; tick(); bus.flag_we = 0;
  endtask

  task automatic test_saturation();
    bus.alu_issue = 1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.alu_ready !== 1'b1) begin
        errors++;
        $display("FAIL sat_ready_before[%0d]: alu_ready=%b required 1", i, bus.alu_ready);
      end
      tick();
    end
    bus.alu_issue = 0;
    checks++;
    if (bus.alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_full: alu_ready=%b required 0", bus.alu_ready);
    end
    bus.alu_issue = 1; bus.flag_we = 1; tick();
    bus.alu_issue = 0;
    checks++;
    if (bus.alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_both: alu_ready=%b required 0", bus.alu_ready);
    end
    tick();
    checks++;
    if (bus.alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_drain: alu_ready=%b required 1", bus.alu_ready);
    end
    tick(); tick(); tick(); // one extra write exercises the clamp at zero
    bus.flag_we = 0;
    exp_q.push_back(model_target(8'h80, 8'h7F));
    drive_jno(8'h80, 8'h7F);
    checks++;
    if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 8'hFF) begin
      errors++;
      $display("FAIL sat_empty_issue: rv=%b rpc=%h required 1 ff", bus.redirect_valid, bus.redirect_pc);
    end
    take_redirect();
  endtask

  task automatic test_flush();
    bus.alu_issue = 1; tick(); bus.alu_issue = 0;
    drive_jno(8'h20, 8'h10);
    checks++;
    if (bus.instruct_from_jno !== 2'b01) begin
      errors++;
      $display("FAIL flush_pre_wait: instr=%b required 01", bus.instruct_from_jno);
    end
    bus.flush = 1;
    drive_jno(8'h40, 8'h01);
    bus.flush = 0;
    checks++;
    if (bus.instruct_from_jno !== 2'b00 || bus.dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: instr=%b dr=%b required 00 1", bus.instruct_from_jno, bus.dec_ready);
    end
    bus.flag_we = 1; bus.ovf_in = 0; tick(); bus.flag_we = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.redirect_valid !== 1'b0 || bus.instruct_from_jno !== 2'b00) begin
        errors++;
        $display("FAIL flush_no_redirect[%0d]: rv=%b instr=%b required 0 00",
                 i, bus.redirect_valid, bus.instruct_from_jno);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) begin
      logic [7:0] pc;
      logic [7:0] off;
      int         hold;
      int         budget;
      pc   = 8'($urandom_range(0, 255));
      off  = 8'($urandom_range(0, 255));
      hold = $urandom_range(0, 2);
      exp_q.push_back(model_target(pc, off));
      drive_jno(pc, off);
      budget = 0;
      while (!bus.redirect_valid && budget < 8) begin
        tick();
        budget++;
      end
      checks++;
      if (bus.redirect_valid !== 1'b1 || budget != 0) begin
        errors++;
        $display("FAIL b2b_issue[%0d]: rv=%b after %0d extra cycles required 1 after 0", n, bus.redirect_valid, budget);
      end
      repeat (hold) tick();
      take_redirect();
    end
  endtask

  task automatic test_reset_mid_issue();
    exp_q.push_back(model_target(8'h10, 8'h05));
    drive_jno(8'h10, 8'h05);
    #2 reset_n = 0;
    #1;
    exp_q.delete();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.instruct_from_jno !== 2'b00 || bus.dec_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_issue: rv=%b instr=%b dr=%b required 0 00 1",
               bus.redirect_valid, bus.instruct_from_jno, bus.dec_ready);
    end
    tick();
    reset_n = 1;
    tick();
    checks++;
    if (bus.redirect_valid !== 1'b0 || bus.redirect_pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_stays_idle: rv=%b rpc=%h required 0 00", bus.redirect_valid, bus.redirect_pc);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset_n = 0;
    idle_inputs();
    tick(); tick();
    test_reset();
    reset_n = 1;
    tick();
    test_taken_hold();
    test_neg_wrap();
    test_pending();
    test_saturation();
    test_flush();
    test_back_to_back();
    test_reset_mid_issue();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d redirects outstanding required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
